// File: rtl/amax10_led_sequencer.sv
// Avalon-MM master that writes a timed LED pattern sequence to the PIO data register
// and reads every write back, raising a sticky error on any mismatch.
module amax10_led_sequencer #(
    parameter int LED_W       = 8,
    parameter int STEP_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [LED_W-1:0] cfg_pattern,
    input  logic             stop,
    input  logic             err_clr,
    output logic [1:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    output logic             busy,
    output logic [LED_W-1:0] cur_pattern,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, WR, RD, WAIT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [LED_W-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [LED_W-1:0]   wdata_q, wdata_d;
    logic [LED_W-1:0]   cur_q, cur_d;
    logic               err_q, err_d;
    logic               accept;
    logic               rd_hi_unused;

    function automatic logic [LED_W-1:0] next_pat(input logic [1:0] m, input logic [LED_W-1:0] p);
        case (m)
            2'd1:    next_pat = {p[LED_W-2:0], p[LED_W-1]};
            2'd2:    next_pat = {p[0], p[LED_W-1:1]};
            2'd3:    next_pat = ~p;
            default: next_pat = p;
        endcase
    endfunction

    // The PIO register holds only LED_W bits; the upper readdata bits carry nothing.
    assign rd_hi_unused = |m_readdata[31:LED_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wdata_q <= '0;
            cur_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wdata_q <= wdata_d;
            cur_q   <= cur_d;
            err_q   <= err_d;
        end
    end

    // Priority in WAIT: stop, then a new configuration, then step expiry.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        accept  = cfg_valid && cfg_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WR;
                    mode_d  = cfg_mode;
                    pat_d   = cfg_pattern;
                end
            end
            WR: state_d = RD;
            RD: begin
                if (mode_q == 2'd0 || stop) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (accept) begin
                    state_d = WR;
                    mode_d  = cfg_mode;
                    pat_d   = cfg_pattern;
                end else if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
                    state_d = WR;
                    pat_d   = next_pat(mode_q, pat_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with the state register.
    always_comb begin
        cfg_ready = (state_q == IDLE || state_q == WAIT) && !stop;
        busy      = (state_q != IDLE);
        cs_d      = (state_d == WR) || (state_d == RD);
        wn_d      = (state_d != WR);
        wdata_d   = (state_d == WR) ? pat_d : wdata_q;
        cur_d     = (state_q == WR) ? pat_q : cur_q;
        err_d     = err_q;
        if (state_q == RD && m_readdata[LED_W-1:0] != pat_q) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    assign m_address    = 2'b00;
    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_writedata  = {{(32-LED_W){1'b0}}, wdata_q};
    assign cur_pattern  = cur_q;
    assign err          = err_q;

endmodule

// File: tb/tb_amax10_led_sequencer.sv
// Bench for amax10_led_sequencer: directed scenarios with literal expectations, then
// random stimulus, all checked every cycle against a write-timing model of the sequencer.
module tb_amax10_led_sequencer;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset, cfg_valid, stop, err_clr, corrupt;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_pattern;
    logic        cfg_ready, m_chipselect, m_write_n, busy, err;
    logic [1:0]  m_address;
    logic [31:0] m_writedata, m_readdata;
    logic [7:0]  cur_pattern;
    logic [7:0]  pio = 8'h00;

    always #5 clk = ~clk;

    amax10_led_sequencer #(.LED_W(8), .STEP_CYCLES(S), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_pattern(cfg_pattern), .stop(stop), .err_clr(err_clr),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .busy(busy),
        .cur_pattern(cur_pattern), .err(err)
    );

    // PIO slave: a plain register; corrupt forces the readback to zero.
    always @(posedge clk) if (m_chipselect && !m_write_n) pio <= m_writedata[7:0];
    assign m_readdata = corrupt ? 32'h0 : {24'h0, pio};

    int n_chk = 0, n_fail = 0, cycle = 0;
    int wr_cyc[$], wr_val[$];
    // Model: m_k counts cycles since the last write strobe (0 = write cycle, 1 = read cycle).
    int m_act = 0, m_k = 0, m_pat = 0, m_mode = 0, m_cur = 0, m_err = 0, m_wdata = 0;

    function automatic int nxt(input int md, input int p);
        case (md)
            1:       return ((p << 1) | (p >> 7)) & 255;
            2:       return (p >> 1) | ((p & 1) << 7);
            3:       return (~p) & 255;
            default: return p;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cycle, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit st, input int mo, input int pa,
                        input bit e, input bit co);
        bit rdy;
        chk("chipselect", int'(m_chipselect), int'(m_act != 0 && m_k <= 1));
        chk("write_n", int'(m_write_n), int'(!(m_act != 0 && m_k == 0)));
        chk("address", int'(m_address), 0);
        chk("writedata", int'(m_writedata), m_wdata);
        chk("cur_pattern", int'(cur_pattern), m_cur);
        chk("err", int'(err), m_err);
        if (m_chipselect && !m_write_n) begin
            wr_cyc.push_back(cycle);
            wr_val.push_back(int'(m_writedata));
        end
        reset = r; cfg_valid = v; stop = st; cfg_mode = 2'(mo); cfg_pattern = 8'(pa);
        err_clr = e; corrupt = co;
        #1;
        rdy = (m_act == 0 || m_k >= 2) && !st;
        chk("cfg_ready", int'(cfg_ready), int'(rdy));
        chk("busy", int'(busy), m_act);
        if (r) begin
            m_act = 0; m_k = 0; m_cur = 0; m_err = 0; m_wdata = 0;
        end else begin
            if (m_act != 0 && m_k == 1 && co && m_pat != 0) m_err = 1;
            else if (e) m_err = 0;
            if (m_act != 0 && m_k == 0) m_cur = m_pat;
            if (m_act == 0 || (m_k >= 2 && !st)) begin
                if (v && rdy) begin
                    m_act = 1; m_k = 0; m_mode = mo; m_pat = pa; m_wdata = pa;
                end else if (m_act != 0 && m_k == S + 1) begin
                    m_pat = nxt(m_mode, m_pat); m_wdata = m_pat; m_k = 0;
                end else if (m_act != 0) begin
                    m_k++;
                end
            end else if (m_k == 0) m_k = 1;
            else if (m_k == 1) begin
                if (m_mode == 0 || st) m_act = 0; else m_k = 2;
            end else m_act = 0;
        end
        cycle++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic halt();
        repeat (3) step(0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic clr_q();
        wr_cyc.delete();
        wr_val.delete();
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 0; stop = 0; err_clr = 0; corrupt = 0;
        cfg_mode = 0; cfg_pattern = 0;
        repeat (2) @(negedge clk);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cs", int'(m_chipselect), 0);
        chk("rst_write_n", int'(m_write_n), 1);
        chk("rst_err", int'(err), 0);

        // Rotate left from 0x01: one full revolution, strobes 6 cycles apart.
        clr_q();
        step(0, 1, 0, 1, 'h01, 0, 0);
        idle(52);
        chk("m1_count", int'(wr_val.size() >= 9), 1);
        for (int i = 0; i < 9 && i < wr_val.size(); i++) begin
            chk("m1_val", wr_val[i], (1 << (i % 8)));
            if (i > 0) chk("m1_period", wr_cyc[i] - wr_cyc[i-1], 6);
        end
        chk("m1_err", int'(err), 0);
        halt();

        clr_q();
        step(0, 1, 0, 2, 'h81, 0, 0);
        idle(14);
        chk("m2_count", int'(wr_val.size() >= 3), 1);
        if (wr_val.size() >= 3) begin
            chk("m2_w1", wr_val[1], 'hC0);
            chk("m2_w2", wr_val[2], 'h60);
        end
        halt();

        clr_q();
        step(0, 1, 0, 3, 'hA5, 0, 0);
        idle(14);
        chk("m3_count", int'(wr_val.size() >= 3), 1);
        if (wr_val.size() >= 3) begin
            chk("m3_w0", wr_val[0], 'hA5);
            chk("m3_w1", wr_val[1], 'h5A);
            chk("m3_w2", wr_val[2], 'hA5);
        end
        halt();

        clr_q();
        step(0, 1, 0, 0, 'h3C, 0, 0);
        idle(10);
        chk("m0_count", wr_val.size(), 1);
        if (wr_val.size() >= 1) chk("m0_val", wr_val[0], 'h3C);
        chk("m0_busy", int'(busy), 0);
        chk("m0_cs", int'(m_chipselect), 0);

        // Readback fault, clear, then clear racing a second fault.
        repeat (3) step(0, 1, 0, 0, 'h55, 0, 1);
        chk("fault_err", int'(err), 1);
        idle(5);
        chk("fault_sticky", int'(err), 1);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("fault_clr", int'(err), 0);
        repeat (3) step(0, 1, 0, 0, 'h55, 1, 1);
        chk("fault_clr_race", int'(err), 1);
        step(0, 0, 0, 0, 0, 1, 0);

        // Stop raised during the write cycle still lets the read complete.
        clr_q();
        step(0, 1, 0, 1, 'h01, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("stopwr_busy", int'(busy), 0);
        chk("stopwr_count", wr_val.size(), 1);

        // Stop beats cfg_valid in WAIT.
        step(0, 1, 0, 1, 'h01, 0, 0);
        idle(4);
        step(0, 1, 1, 3, 'hF0, 0, 0);
        clr_q();
        idle(10);
        chk("stopwait_count", wr_val.size(), 0);
        chk("stopwait_busy", int'(busy), 0);

        // Reconfigure at WAIT count 2, then reset during the following read.
        step(0, 1, 0, 1, 'h01, 0, 0);
        idle(4);
        clr_q();
        step(0, 1, 0, 3, 'hF0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("reconf_count", wr_val.size(), 1);
        if (wr_val.size() >= 1) chk("reconf_val", wr_val[0], 'hF0);
        chk("reconf_rd_cs", int'(m_chipselect), 1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rrst_cs", int'(m_chipselect), 0);
        chk("rrst_write_n", int'(m_write_n), 1);
        chk("rrst_wdata", int'(m_writedata), 0);
        chk("rrst_cur", int'(cur_pattern), 0);
        chk("rrst_busy", int'(busy), 0);
        chk("rrst_ready", int'(cfg_ready), 1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom % 200 == 0, $urandom % 3 == 0, $urandom % 16 == 0,
                 int'($urandom % 4), int'($urandom % 256), $urandom % 10 == 0, $urandom % 8 == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
